// File: rtl/utmi_tx_pkg.sv
// Shared UTMI transmit definitions.
// Holds the arbiter state encoding, the one-hot grant constants and the default timing/size
// constants reused by the arbiter and the UTMI TX FSM bench.
package utmi_tx_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StGrant0 = 2'b01,
      StGrant1 = 2'b10,
      StGap    = 2'b11
   } arb_state_e;

   localparam logic [1:0] GrantNone = 2'b00;
   localparam logic [1:0] Grant0Oh  = 2'b01;
   localparam logic [1:0] Grant1Oh  = 2'b10;

   localparam int unsigned DefIpgCycles   = 16;
   localparam int unsigned DefMaxPktBytes = 1027;

endpackage

// File: rtl/utmi_tx_gap_timer.sv
// Loadable down-counter with a zero flag.
// Ports:
//   Clk, Rst     clock and asynchronous active-low reset
//   load_i       load load_val_i this cycle (has priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one; holds at zero
//   zero_o       counter currently zero
module utmi_tx_gap_timer #(
   parameter int unsigned W = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/utmi_tx_arbiter.sv
// Two-source arbiter for the UTMI transmit interface.
// Requester 0 (SOF generator) has priority over requester 1 (transaction engine). Grants last
// a whole packet, each packet is followed by IPG_CYCLES idle cycles, and sof_guard keeps new
// requester-1 packets off the bus near a frame boundary.
// Ports:
//   Clk, Rst                  clock and asynchronous active-low reset
//   req0_* / req1_*           valid/data/ready of the two packet sources
//   sof_guard                 blocks new requester-1 grants
//   TX_Valid, DataIn          towards the UTMI TX FSM
//   TX_Ready                  byte taken by the UTMI TX FSM
//   grant                     one-hot owner, busy = not idle, pkt_done = packet-end pulse
//   byte_cnt                  bytes accepted in the current/last packet (saturating)
//   overrun_err, err_clr      sticky oversize flag and its synchronous clear
module utmi_tx_arbiter
   import utmi_tx_pkg::*;
#(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned IPG_CYCLES    = DefIpgCycles,
   parameter int unsigned MAX_PKT_BYTES = DefMaxPktBytes,
   parameter int unsigned CNT_W         = 11
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              sof_guard,
   output logic              TX_Valid,
   output logic [DATA_W-1:0] DataIn,
   input  logic              TX_Ready,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              pkt_done,
   output logic [CNT_W-1:0]  byte_cnt,
   output logic              overrun_err,
   input  logic              err_clr
);

   localparam int unsigned GapW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   arb_state_e       state_d, state_q;
   logic [CNT_W-1:0] byte_cnt_d, byte_cnt_q;
   logic             overrun_d, overrun_q;
   logic             pkt_done_d, pkt_done_q;
   logic             pkt_end;
   logic             accept;
   logic             gap_zero;

   // Owner dropping valid ends the packet; this also loads the gap timer.
   assign pkt_end = ((state_q == StGrant0) && !req0_valid) ||
                    ((state_q == StGrant1) && !req1_valid);

   utmi_tx_gap_timer #(
      .W (GapW)
   ) u_gap_timer (
      .Clk        (Clk),
      .Rst        (Rst),
      .load_i     (pkt_end),
      .load_val_i (GapW'(IPG_CYCLES - 1)),
      .dec_i      (state_q == StGap),
      .zero_o     (gap_zero)
   );

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req0_valid) begin
               state_d = StGrant0;
            end else if (req1_valid && !sof_guard) begin
               state_d = StGrant1;
            end
         end
         StGrant0: if (!req0_valid) state_d = StGap;
         StGrant1: if (!req1_valid) state_d = StGap;
         StGap:    if (gap_zero)    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic: datapath mux decoded from the registered state
   always_comb begin
      TX_Valid   = 1'b0;
      DataIn     = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant      = GrantNone;
      unique case (state_q)
         StGrant0: begin
            TX_Valid   = req0_valid;
            DataIn     = req0_data;
            req0_ready = TX_Ready;
            grant      = Grant0Oh;
         end
         StGrant1: begin
            TX_Valid   = req1_valid;
            DataIn     = req1_data;
            req1_ready = TX_Ready;
            grant      = Grant1Oh;
         end
         default: begin
            grant = GrantNone;
         end
      endcase
   end

   assign busy   = (state_q != StIdle);
   // A byte only counts if the owner still presents it.
   assign accept = TX_Valid && TX_Ready;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if ((state_q == StIdle) && (state_d != StIdle)) begin
         byte_cnt_d = '0;
      end else if (accept && (byte_cnt_q != '1)) begin
         byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
   end

   // Set has priority over clear.
   always_comb begin
      overrun_d = overrun_q && !err_clr;
      if (accept && (byte_cnt_q == CNT_W'(MAX_PKT_BYTES))) begin
         overrun_d = 1'b1;
      end
   end

   assign pkt_done_d = pkt_end;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         byte_cnt_q <= '0;
         overrun_q  <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         overrun_q  <= overrun_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   assign byte_cnt    = byte_cnt_q;
   assign overrun_err = overrun_q;
   assign pkt_done    = pkt_done_q;

endmodule
